// File: rtl/adec_pkg.sv
// rtl/adec_pkg.sv - shared encodings and reset-map constants for the programmable address decoder
// Contents: cfg_field encodings, wait-state FSM states, default window map (windows 0-4).
// Optional feature macro used by importers: ADEC_WRITE_PROTECT_EN.
package adec_pkg;

    typedef enum logic [1:0] {
        FLD_BASE  = 2'd0,
        FLD_MASK  = 2'd1,
        FLD_WAITS = 2'd2,
        FLD_EN    = 2'd3
    } cfg_field_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ws_state_e;

    localparam int DEF_WINDOWS = 5;

    // C64-style I/O map so existing software boots without reprogramming.
    function automatic logic [18:0] def_base(input int idx);
        case (idx)
            0:       return 19'h0D400;  // SID
            1:       return 19'h0DC00;  // VIA1
            2:       return 19'h0DC10;  // VIA2
            3:       return 19'h0DC20;  // UART
            4:       return 19'h0DE00;  // Bifrost registers
            default: return 19'h00000;
        endcase
    endfunction

    function automatic logic [18:0] def_mask(input int idx);
        case (idx)
            0:       return 19'h7FC00;
            1:       return 19'h7FFF0;
            2:       return 19'h7FFF0;
            3:       return 19'h7FFF0;
            4:       return 19'h7FE00;
            default: return 19'h00000;
        endcase
    endfunction

    function automatic logic def_en(input int idx);
        return (idx < DEF_WINDOWS);
    endfunction

endpackage

// File: rtl/adec_if.sv
// rtl/adec_if.sv - CPU bus / config bundle between a bus master and the address decoder
// Signals: addr, rw, bus_start (CPU side); cfg_we, cfg_sel, cfg_field, cfg_wdata (config side);
// cs_n, ram_cs_n, rdy (decoder outputs); wp_err when ADEC_WRITE_PROTECT_EN is defined.
// Modports: master (drives bus/config), slave (the decoder).
interface adec_if #(
    parameter int ADDR_W = 19,
    parameter int N_CS   = 8
);
    localparam int SEL_W = (N_CS > 1) ? $clog2(N_CS) : 1;

    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              bus_start;
    logic              cfg_we;
    logic [SEL_W-1:0]  cfg_sel;
    logic [1:0]        cfg_field;
    logic [ADDR_W-1:0] cfg_wdata;
    logic [N_CS-1:0]   cs_n;
    logic              ram_cs_n;
    logic              rdy;
`ifdef ADEC_WRITE_PROTECT_EN
    logic              wp_err;
`endif

    modport master (
        output addr, rw, bus_start, cfg_we, cfg_sel, cfg_field, cfg_wdata,
        input  cs_n, ram_cs_n, rdy
`ifdef ADEC_WRITE_PROTECT_EN
        , input wp_err
`endif
    );

    modport slave (
        input  addr, rw, bus_start, cfg_we, cfg_sel, cfg_field, cfg_wdata,
        output cs_n, ram_cs_n, rdy
`ifdef ADEC_WRITE_PROTECT_EN
        , output wp_err
`endif
    );
endinterface

// File: rtl/adec_window.sv
// rtl/adec_window.sv - one programmable chip-select window: base/mask/waits/enable registers plus comparator
// Ports: clock, reset_n (sync active-low), we (config write already qualified for this window),
// field, wdata, addr -> match, waits; ro when ADEC_WRITE_PROTECT_EN is defined.
module adec_window
    import adec_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int WS_W   = 3,
    parameter int IDX    = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic [1:0]        field,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [ADDR_W-1:0] addr,
    output logic              match,
    output logic [WS_W-1:0]   waits
`ifdef ADEC_WRITE_PROTECT_EN
    ,
    output logic              ro
`endif
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] mask;
    logic              en;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            base  <= ADDR_W'(def_base(IDX));
            mask  <= ADDR_W'(def_mask(IDX));
            en    <= def_en(IDX);
            waits <= '0;
`ifdef ADEC_WRITE_PROTECT_EN
            ro    <= 1'b0;
`endif
        end else if (we) begin
            case (cfg_field_e'(field))
                FLD_BASE:  base  <= wdata;
                FLD_MASK:  mask  <= wdata;
                FLD_WAITS: waits <= wdata[WS_W-1:0];
                FLD_EN: begin
                    en <= wdata[0];
`ifdef ADEC_WRITE_PROTECT_EN
                    ro <= wdata[1];
`endif
                end
                default: ;
            endcase
        end
    end

    // Registers are read directly, so a same-cycle config write only affects later decodes.
    assign match = en && (((addr ^ base) & mask) == '0);

endmodule

// File: rtl/adec_prog.sv
// rtl/adec_prog.sv - programmable address decoder with priority chip selects and 6502 RDY wait-state FSM
// Ports: clock, reset_n (sync active-low), bus (adec_if.slave: addr, rw, bus_start, cfg_*,
// cs_n, ram_cs_n, rdy, plus wp_err when ADEC_WRITE_PROTECT_EN is defined).
// Optional feature macro: ADEC_WRITE_PROTECT_EN (per-window read-only bit and sticky wp_err).
module adec_prog
    import adec_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int N_CS   = 8,
    parameter int WS_W   = 3
) (
    input  logic  clock,
    input  logic  reset_n,
    adec_if.slave bus
);

    localparam int SEL_W = (N_CS > 1) ? $clog2(N_CS) : 1;

    logic [N_CS-1:0]           match;
    logic [N_CS-1:0][WS_W-1:0] waits;
    logic [N_CS-1:0]           ro;

    for (genvar i = 0; i < N_CS; i++) begin : g_win
        // Selects outside 0..N_CS-1 equal no window index, so those writes are dropped.
        logic win_we;
        assign win_we = bus.cfg_we && (bus.cfg_sel == SEL_W'(i));

        adec_window #(.ADDR_W(ADDR_W), .WS_W(WS_W), .IDX(i)) u_win (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (win_we),
            .field   (bus.cfg_field),
            .wdata   (bus.cfg_wdata),
            .addr    (bus.addr),
            .match   (match[i]),
            .waits   (waits[i])
`ifdef ADEC_WRITE_PROTECT_EN
            ,
            .ro      (ro[i])
`endif
        );
`ifndef ADEC_WRITE_PROTECT_EN
        assign ro[i] = 1'b0;
`endif
    end

    // Priority encode: scanning downward lets the lowest matching index win.
    logic             hit;
    logic [SEL_W-1:0] win_idx;
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int i = N_CS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                win_idx = SEL_W'(i);
            end
        end
    end

    // A write into a read-only winner selects nothing at all: no window and no RAM.
    logic blocked;
    logic sel_hit;
`ifdef ADEC_WRITE_PROTECT_EN
    assign blocked = hit && ro[win_idx] && !bus.rw;
`else
    logic unused_rw;
    logic unused_ro;
    assign unused_rw = bus.rw;
    assign unused_ro = |ro;
    assign blocked   = 1'b0;
`endif
    assign sel_hit = hit && !blocked;

    always_comb begin
        bus.cs_n = '1;
        if (sel_hit) bus.cs_n[win_idx] = 1'b0;
    end
    assign bus.ram_cs_n = hit;

    // Wait-state FSM: loading k-1 and counting down through zero gives exactly k stall cycles.
    ws_state_e       state, state_d;
    logic [WS_W-1:0] cnt, cnt_d;
    logic [WS_W-1:0] start_k;

    assign start_k = waits[win_idx];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE, S_HOLD: begin
                state_d = S_IDLE;
                if (bus.bus_start && sel_hit && (start_k != '0)) begin
                    state_d = S_WAIT;
                    cnt_d   = start_k - WS_W'(1);
                end
            end
            S_WAIT: begin
                // bus_start and config writes are ignored here; the latched count runs out.
                if (cnt == '0) state_d = S_HOLD;
                else           cnt_d   = cnt - WS_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rdy = (state != S_WAIT);

`ifdef ADEC_WRITE_PROTECT_EN
    always_ff @(posedge clock) begin
        if (!reset_n)                        bus.wp_err <= 1'b0;
        else if (bus.bus_start && blocked)   bus.wp_err <= 1'b1;
        else if (bus.cfg_we)                 bus.wp_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_adec_prog.sv
// tb/tb_adec_prog.sv - directed self-checking bench for adec_prog (also covers ADEC_WRITE_PROTECT_EN when defined)
module tb_adec_prog;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    adec_if #(.ADDR_W(19), .N_CS(8)) bus ();

    adec_prog #(.ADDR_W(19), .N_CS(8), .WS_W(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.bus_start = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.rw        = 1'b1;
        bus.cfg_sel   = '0;
        bus.cfg_field = '0;
        bus.cfg_wdata = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [1:0] field, input logic [18:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel;
        bus.cfg_field = field;
        bus.cfg_wdata = data;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] va [10] = '{19'h0D41F, 19'h0C000, 19'h0D7FF, 19'h0D800, 19'h0DC0F,
                                 19'h0DC10, 19'h0DC2F, 19'h0DC30, 19'h0DFFF, 19'h4D400};
        logic [7:0]  vc [10] = '{8'hFE, 8'hFF, 8'hFE, 8'hFF, 8'hFD,
                                 8'hFB, 8'hF7, 8'hFF, 8'hEF, 8'hFF};
        logic        vr [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.addr = 19'h0D41F;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy got=%b exp=1", bus.rdy);
        end
`ifdef ADEC_WRITE_PROTECT_EN
        checks++;
        if (bus.wp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_wp_err got=%b exp=0", bus.wp_err);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            step();
            bus.addr = va[i];
            @(negedge clock);
            checks++;
            if (bus.cs_n !== vc[i]) begin
                failures++;
                $display("FAIL default_map_cs_n addr=%h got=%h exp=%h", va[i], bus.cs_n, vc[i]);
            end
            checks++;
            if (bus.ram_cs_n !== vr[i]) begin
                failures++;
                $display("FAIL default_map_ram_cs_n addr=%h got=%b exp=%b", va[i], bus.ram_cs_n, vr[i]);
            end
        end
        step();
    endtask

    task automatic test_priority();
        do_reset();
        cfg_write(3'd5, 2'd0, 19'h0D400);
        cfg_write(3'd5, 2'd1, 19'h7FC00);
        cfg_write(3'd5, 2'd3, 19'h00001);
        bus.addr = 19'h0D400;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFE) begin
            failures++;
            $display("FAIL priority_low_wins got=%h exp=fe", bus.cs_n);
        end
        step();
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 3'd0;
        bus.cfg_field = 2'd3;
        bus.cfg_wdata = 19'h00000;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFE) begin
            failures++;
            $display("FAIL disable_same_cycle got=%h exp=fe", bus.cs_n);
        end
        step();
        bus.cfg_we = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hDF || bus.ram_cs_n !== 1'b1) begin
            failures++;
            $display("FAIL disable_next_edge got=%h/%b exp=df/1", bus.cs_n, bus.ram_cs_n);
        end
        step();
    endtask

    task automatic test_waits();
        logic exp3 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp7 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        cfg_write(3'd3, 2'd2, 19'h00003);
        bus.addr      = 19'h0DC25;
        bus.bus_start = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1 || bus.cs_n !== 8'hF7) begin
            failures++;
            $display("FAIL wait_start_cycle got=%b/%h exp=1/f7", bus.rdy, bus.cs_n);
        end
        step();
        bus.bus_start = 1'b0;
        // bus_start pulsed again in the second stall cycle must be ignored
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            checks++;
            if (bus.rdy !== exp3[j]) begin
                failures++;
                $display("FAIL wait3_rdy cycle=%0d got=%b exp=%b", j, bus.rdy, exp3[j]);
            end
            step();
            bus.bus_start = (j == 0);
        end

        // waits reprogrammed to 7 in the first stall cycle: this stall stays 3
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 3'd3;
        bus.cfg_field = 2'd2;
        bus.cfg_wdata = 19'h00007;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            checks++;
            if (bus.rdy !== exp3[j]) begin
                failures++;
                $display("FAIL reprogram_in_wait_rdy cycle=%0d got=%b exp=%b", j, bus.rdy, exp3[j]);
            end
            step();
            bus.cfg_we = 1'b0;
        end

        // maximum stall of 7
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clock);
            checks++;
            if (bus.rdy !== exp7[j]) begin
                failures++;
                $display("FAIL wait7_rdy cycle=%0d got=%b exp=%b", j, bus.rdy, exp7[j]);
            end
            step();
        end
    endtask

    task automatic test_zero_waits();
        do_reset();
        bus.addr      = 19'h0D400;
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1) begin
            failures++;
            $display("FAIL zero_waits_rdy got=%b exp=1", bus.rdy);
        end
        step();
        bus.addr      = 19'h0C000;
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1) begin
            failures++;
            $display("FAIL no_match_rdy got=%b exp=1", bus.rdy);
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        cfg_write(3'd0, 2'd3, 19'h00000);
        cfg_write(3'd3, 2'd2, 19'h00003);
        bus.addr      = 19'h0DC25;
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_cycle1 got=%b exp=0", bus.rdy);
        end
        step();
        reset_n  = 1'b0;
        bus.addr = 19'h0D400;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b0 || bus.cs_n !== 8'hFF) begin
            failures++;
            $display("FAIL rst_wait_cycle2 got=%b/%h exp=0/ff", bus.rdy, bus.cs_n);
        end
        step();
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1 || bus.cs_n !== 8'hFE || bus.ram_cs_n !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_wait_restore got=%b/%h/%b exp=1/fe/1", bus.rdy, bus.cs_n, bus.ram_cs_n);
        end
        step();
        bus.addr      = 19'h0DC25;
        bus.bus_start = 1'b1;
        step();
        bus.bus_start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.rdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_cleared_waits got=%b exp=1", bus.rdy);
        end
        step();
    endtask

    task automatic test_same_cycle_cfg();
        do_reset();
        bus.addr      = 19'h0DC00;
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = 3'd1;
        bus.cfg_field = 2'd0;
        bus.cfg_wdata = 19'h0E000;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFD) begin
            failures++;
            $display("FAIL same_cycle_old_base got=%h exp=fd", bus.cs_n);
        end
        step();
        bus.cfg_we = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFF || bus.ram_cs_n !== 1'b0) begin
            failures++;
            $display("FAIL next_cycle_new_base got=%h/%b exp=ff/0", bus.cs_n, bus.ram_cs_n);
        end
        step();
        bus.addr = 19'h0E005;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFD) begin
            failures++;
            $display("FAIL moved_window got=%h exp=fd", bus.cs_n);
        end
        step();
    endtask

`ifdef ADEC_WRITE_PROTECT_EN
    task automatic test_write_protect();
        do_reset();
        cfg_write(3'd4, 2'd3, 19'h00003);
        bus.addr      = 19'h0DE10;
        bus.rw        = 1'b0;
        bus.bus_start = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.cs_n !== 8'hFF || bus.ram_cs_n !== 1'b1 || bus.wp_err !== 1'b0) begin
            failures++;
            $display("FAIL wp_write_blocked got=%h/%b/%b exp=ff/1/0", bus.cs_n, bus.ram_cs_n, bus.wp_err);
        end
        step();
        bus.bus_start = 1'b0;
        bus.rw        = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.wp_err !== 1'b1 || bus.cs_n !== 8'hEF) begin
            failures++;
            $display("FAIL wp_err_set_read_ok got=%b/%h exp=1/ef", bus.wp_err, bus.cs_n);
        end
        step();
        cfg_write(3'd2, 2'd2, 19'h00000);
        @(negedge clock);
        checks++;
        if (bus.wp_err !== 1'b0) begin
            failures++;
            $display("FAIL wp_err_clear got=%b exp=0", bus.wp_err);
        end
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.addr = '0;
        idle_bus();
        test_reset();
        test_priority();
        test_waits();
        test_zero_waits();
        test_reset_in_wait();
        test_same_cycle_cfg();
`ifdef ADEC_WRITE_PROTECT_EN
        test_write_protect();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
